// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - add/subtract split into STAGES carry-registered slices
// Elastic pipeline: every stage shifts on the single global advance.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE = WIDTH'({SW{1'b1}});

  logic advance;

  // registered stage state
  logic [WIDTH-1:0]  ar [STAGES];
  logic [WIDTH-1:0]  br [STAGES];
  logic [WIDTH-1:0]  yr [STAGES];
  logic [STAGES-1:0] vld, cry, am, bm;
  logic              zero_r;

  // next-state values feeding each stage register
  logic [WIDTH-1:0]  na [STAGES];
  logic [WIDTH-1:0]  nb [STAGES];
  logic [WIDTH-1:0]  ny [STAGES];
  logic [STAGES-1:0] nc, nv, nam, nbm;

  assign advance  = ~vld[L] | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] src_y;
    logic             cin_k;
    logic [SW:0]      sum;

    if (k == 0) begin : g_first
      // subtraction is a + ~b + 1, so the stage-0 carry doubles as the +1
      assign na[k]  = a;
      assign nb[k]  = sub ? ~b : b;
      assign cin_k  = sub | cin;
      assign src_y  = '0;
      assign nv[k]  = in_valid;
      assign nam[k] = a[WIDTH-1];
      assign nbm[k] = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else begin : g_rest
      assign na[k]  = ar[k-1];
      assign nb[k]  = br[k-1];
      assign cin_k  = cry[k-1];
      assign src_y  = yr[k-1];
      assign nv[k]  = vld[k-1];
      assign nam[k] = am[k-1];
      assign nbm[k] = bm[k-1];
    end

    assign sum   = {1'b0, na[k][k*SW +: SW]} + {1'b0, nb[k][k*SW +: SW]} + (SW+1)'(cin_k);
    assign nc[k] = sum[SW];
    assign ny[k] = (src_y & ~(SLICE << (k*SW))) | (WIDTH'(sum[SW-1:0]) << (k*SW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      cry    <= '0;
      am     <= '0;
      bm     <= '0;
      zero_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        ar[k] <= '0;
        br[k] <= '0;
        yr[k] <= '0;
      end
    end else if (advance) begin
      vld    <= nv;
      cry    <= nc;
      am     <= nam;
      bm     <= nbm;
      zero_r <= (ny[L] == '0);
      for (int k = 0; k < STAGES; k++) begin
        ar[k] <= na[k];
        br[k] <= nb[k];
        yr[k] <= ny[k];
      end
    end
  end

  assign out_valid = vld[L];
  assign y         = yr[L];
  assign cout      = cry[L];
  assign zero      = zero_r;
  // all terms come from last-stage registers, so ovf is 0 in reset and held in a stall
  assign ovf       = (am[L] == bm[L]) & (yr[L][WIDTH-1] != am[L]);

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline depth; WIDTH SHALL be an integer multiple of STAGES; legal range 1..WIDTH.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in, add mode only.
REQ-010 Port sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b), cin ignored.
REQ-011 Port out_valid  output  1  result fields valid.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Port y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 Port cout  output  1  carry out of MSB; in sub mode 1 = no borrow (a >= b unsigned).
REQ-015 Port ovf  output  1  two's-complement signed overflow.
REQ-016 Port zero  output  1  y == 0.

Function
REQ-017 Datapath SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k SHALL be added in stage k using the carry registered from stage k-1.
REQ-018 Sub mode SHALL compute a + ~b + 1; stage-0 carry-in SHALL be sub ? 1 : cin.
REQ-019 Operand slices not yet consumed SHALL be carried forward in stage registers; completed result slices SHALL be carried forward so y is aligned at the output.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-021 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-022 Global advance = ~out_valid | out_ready; in_ready SHALL equal advance (combinational).
REQ-023 When advance = 0, every stage register, valid bit and output SHALL hold unchanged.
REQ-024 When advance = 1 and in_valid = 0, a bubble (valid bit 0) SHALL enter stage 0.
REQ-025 Each stage SHALL carry a valid bit; out_valid SHALL be the last stage's valid bit.
REQ-026 ovf SHALL be (a_msb == b_eff_msb) & (y_msb != a_msb), b_eff = sub ? ~b : b, using captured operand MSBs.
REQ-027 y, cout, ovf, zero SHALL be registered and stable while out_valid & ~out_ready.
REQ-028 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated.
REQ-029 STAGES = 1 SHALL degenerate to one registered full-width adder with latency 1.

Reset
REQ-030 While rst = 1: all valid bits 0, out_valid 0, y 0, cout 0, ovf 0, zero 0, regardless of clk.
REQ-031 rst asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-032 First rising clk edge after rst deasserts SHALL be able to accept an operation (in_ready = 1 since out_valid = 0).

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, y=0x00000000, cout=1, ovf=0, zero=1.
REQ-034 a=0x7FFFFFFF, b=0x00000001, add -> y=0x80000000, ovf=1, cout=0; a=5, b=7, sub=1 -> y=0xFFFFFFFE, cout=0, ovf=0, zero=0.
REQ-035 Stream 10 back-to-back random ops, out_ready=1 -> 10 consecutive out_valid cycles, in order, matching a+b+cin / a-b reference model.
REQ-036 Stream ops with out_ready low for 3 cycles mid-stream -> in_ready=0 during stall, output held stable, no loss/duplication, order preserved.
REQ-037 Accept 2 ops, assert rst asynchronously between clock edges -> out_valid and all outputs 0 immediately; neither op appears after release.
REQ-038 Repeat REQ-033/035 with STAGES=1 and STAGES=8 -> latency 1 and 8 respectively, identical results.
